// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus; grant held until ack or abort.
// Optional ack timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
`ifdef BUS_ARBITER_TIMEOUT_EN
  ,
  output logic                  m0_err_o,
  output logic                  m1_err_o
`endif
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic                  busy;
  logic                  timeout;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    busy    = (state_q == ST_BUSY);
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    own_we  = owner_q ? m1_we_i  : m0_we_i;
    own_adr = owner_q ? m1_adr_i : m0_adr_i;
    own_dat = owner_q ? m1_dat_i : m0_dat_i;
    timeout = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    // an ack arriving in the expiry cycle completes normally
    timeout = busy && !s_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif
  end

  always_comb begin
    s_stb_o  = busy && own_stb && !timeout;
    s_we_o   = busy ? own_we  : 1'b0;
    s_adr_o  = busy ? own_adr : '0;
    s_dat_o  = busy ? own_dat : '0;
    grant_o  = busy ? {owner_q, ~owner_q} : 2'b00;
    m0_ack_o = busy && !owner_q && s_ack_i;
    m1_ack_o = busy &&  owner_q && s_ack_i;
    m0_dat_o = (busy && !owner_q) ? s_dat_i : '0;
    m1_dat_o = (busy &&  owner_q) ? s_dat_i : '0;
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  assign m0_err_o = timeout && !owner_q;
  assign m1_err_o = timeout &&  owner_q;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          owner_d = (m0_stb_i && m1_stb_i) ? ~last_q : m1_stb_i;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_stb || s_ack_i || timeout) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!s_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_stb = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_wdat = '0;
  logic [DW-1:0] m0_rdat;
  logic          m0_ack;
  logic          m1_stb = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_wdat = '0;
  logic [DW-1:0] m1_rdat;
  logic          m1_ack;
  logic          s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [DW-1:0] s_rdat = '0;
  logic          s_ack = 1'b0;
  logic [1:0]    grant;
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic          m0_err, m1_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant)
`ifdef BUS_ARBITER_TIMEOUT_EN
    , .m0_err_o(m0_err), .m1_err_o(m1_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
      checks++;
      if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_sstb got %b want 0", s_stb); end
      checks++;
      if ({m0_ack, m1_ack} !== 2'b00) begin
        errors++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack});
      end
    end
    s_ack = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", grant); end
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick();
  endtask

  task automatic test_read();
    do_reset();
    m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
    tick();
    checks++;
    if ({grant, s_stb, s_we, s_adr} !== {2'b01, 1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL read_fwd got %b %b %b %h want 01 1 0 100", grant, s_stb, s_we, s_adr);
    end
    tick();
    checks++;
    if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack got %b want 0", m0_ack); end
    tick();
    s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_ack, m0_rdat} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_ack got %b %h want 1 deadbeef", m0_ack, m0_rdat);
    end
    checks++;
    if ({m1_ack, m1_rdat} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL read_other got %b %h want 0 0", m1_ack, m1_rdat);
    end
    tick();
    m0_stb = 1'b0; s_ack = 1'b0;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL read_release got %b want 00", grant); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    int n0 = 0, n1 = 0;
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== want[i]) begin
        errors++; $display("FAIL b2b_grant[%0d] got %b want %b", i, grant, want[i]);
      end
      n0 += int'(m0_ack); n1 += int'(m1_ack);
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin errors++; $display("FAIL b2b_acks got %0d/%0d want 2/2", n0, n1); end
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_abort();
    do_reset();
    m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h200; m1_wdat = 32'h5A;
    tick();
    checks++;
    if ({grant, s_stb, s_we, s_adr, s_wdat} !== {2'b10, 1'b1, 1'b1, 32'h200, 32'h5A}) begin
      errors++; $display("FAIL abort_fwd got %b %b %b %h %h", grant, s_stb, s_we, s_adr, s_wdat);
    end
    m1_stb = 1'b0;
    #1;
    checks++;
    if (s_stb !== 1'b0) begin errors++; $display("FAIL abort_sstb got %b want 0", s_stb); end
    tick();
    s_ack = 1'b1;
    #1;
    checks++;
    if ({grant, m0_ack, m1_ack} !== 4'b0000) begin
      errors++; $display("FAIL abort_late_ack got %b %b %b want 00 0 0", grant, m0_ack, m1_ack);
    end
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_stb = 1'b1; m0_adr = 32'h300;
    tick();
    reset = 1'b0; m1_stb = 1'b1;
    tick();
    checks++;
    if ({s_stb, grant} !== 3'b000) begin
      errors++; $display("FAIL midreset got %b %b want 0 00", s_stb, grant);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL midreset_regrant got %b want 01", grant); end
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      checks++;
      if ({s_stb, m0_err, grant} !== 4'b1001) begin
        errors++; $display("FAIL to_wait[%0d] got %b %b %b want 1 0 01", i, s_stb, m0_err, grant);
      end
    end
    tick();
    checks++;
    if ({s_stb, m0_err, m1_err} !== 3'b010) begin
      errors++; $display("FAIL to_err got %b %b %b want 0 1 0", s_stb, m0_err, m1_err);
    end
    m0_stb = 1'b0;
    tick();
    checks++;
    if ({grant, m0_err} !== 3'b000) begin errors++; $display("FAIL to_idle got %b %b", grant, m0_err); end
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL to_pending got %b want 10", grant); end
    m1_stb = 1'b0;
    tick(); tick();
  endtask
`endif

  // Reference: owner is -1 while the bus is free; a transaction ends on ack, abort or timeout.
  task automatic test_random();
    int mown, mlast, mcnt;
    logic busy, to, ostb;
    logic [133:0] act, exp;
    do_reset();
    mown = -1; mlast = 1; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      m0_stb = m0_stb ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      m1_stb = m1_stb ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = $urandom; m1_adr = $urandom; m0_wdat = $urandom; m1_wdat = $urandom;
      s_ack = ($urandom_range(0, 4) < 2); s_rdat = $urandom;
      #2;
      busy = (mown >= 0);
      ostb = (mown == 1) ? m1_stb : m0_stb;
      to = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      to = busy && !s_ack && (mcnt == TO);
`endif
      exp = {busy && ostb && !to,
             busy ? ((mown == 1) ? m1_we : m0_we) : 1'b0,
             busy ? ((mown == 1) ? m1_adr : m0_adr) : 32'h0,
             busy ? ((mown == 1) ? m1_wdat : m0_wdat) : 32'h0,
             busy ? ((mown == 1) ? 2'b10 : 2'b01) : 2'b00,
             busy && mown == 0 && s_ack, busy && mown == 1 && s_ack,
             (busy && mown == 0) ? s_rdat : 32'h0,
             (busy && mown == 1) ? s_rdat : 32'h0};
      act = {s_stb, s_we, s_adr, s_wdat, grant, m0_ack, m1_ack, m0_rdat, m1_rdat};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL random[%0d] got %h want %h", c, act, exp);
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      checks++;
      if ({m0_err, m1_err} !== {to && mown == 0, to && mown == 1}) begin
        errors++; $display("FAIL random_err[%0d] got %b%b want %b%b", c, m0_err, m1_err,
                           to && mown == 0, to && mown == 1);
      end
`endif
      if (!busy) begin
        if (m0_stb || m1_stb) begin
          mown = (m0_stb && m1_stb) ? 1 - mlast : (m1_stb ? 1 : 0);
          mcnt = 0;
        end
      end else if (!ostb || s_ack || to) begin
        mlast = mown; mown = -1;
      end else begin
        mcnt++;
      end
      tick();
    end
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
